// File: rtl/mem_copy_engine.sv
// Byte-serial memory copy engine: reads one byte, writes it, advances both
// pointers, and pulses done when the requested length has been moved.
// Optional feature macro: MEM_COPY_CHECKSUM_EN adds a running modulo checksum output.
module mem_copy_engine #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W-1:0] length,
    output logic              busy,
    output logic              done,
    output logic              memWrite,
    output logic              memRead,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] data,
    input  logic [DATA_W-1:0] out
`ifdef MEM_COPY_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] byte_q, byte_d;

`ifdef MEM_COPY_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q, sum_d;
    assign checksum = sum_q;
`endif

    // State and datapath registers; async reset clears everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            byte_q  <= '0;
`ifdef MEM_COPY_CHECKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            byte_q  <= byte_d;
`ifdef MEM_COPY_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

    // Next-state, datapath updates and memory strobes decoded from the current state.
    always_comb begin
        state_d  = state_q;
        src_d    = src_q;
        dst_d    = dst_q;
        cnt_d    = cnt_q;
        byte_d   = byte_q;
`ifdef MEM_COPY_CHECKSUM_EN
        sum_d    = sum_q;
`endif
        busy     = 1'b1;
        done     = 1'b0;
        memRead  = 1'b0;
        memWrite = 1'b0;
        address  = '0;
        data     = '0;

        unique case (state_q)
            StIdle: begin
                busy = 1'b0;
                if (start) begin
                    src_d   = src_addr;
                    dst_d   = dst_addr;
                    cnt_d   = length;
`ifdef MEM_COPY_CHECKSUM_EN
                    sum_d   = '0;
`endif
                    state_d = (length != '0) ? StRead : StDone;
                end
            end
            StRead: begin
                memRead = 1'b1;
                address = src_q;
                byte_d  = out;
`ifdef MEM_COPY_CHECKSUM_EN
                sum_d   = sum_q + out;
`endif
                state_d = StWrite;
            end
            StWrite: begin
                memWrite = 1'b1;
                address  = dst_q;
                data     = byte_q;
                // Pointers wrap naturally at 2^ADDR_W.
                src_d    = src_q + ADDR_W'(1);
                dst_d    = dst_q + ADDR_W'(1);
                cnt_d    = cnt_q - ADDR_W'(1);
                state_d  = (cnt_q == ADDR_W'(1)) ? StDone : StRead;
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Self-checking bench for mem_copy_engine: a behavioural memory, a scoreboard of
// expected read/write operations, and directed copy scenarios.
module tb_mem_copy_engine;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] src_addr, dst_addr, length;
    logic       busy, done, memWrite, memRead;
    logic [7:0] address, data, out;
`ifdef MEM_COPY_CHECKSUM_EN
    logic [7:0] checksum;
`endif

    logic [7:0] mem [256];

    typedef struct packed {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] dat;
    } op_t;

    op_t exp_q[$];
    int  checks   = 0;
    int  failures = 0;
    int  done_cnt = 0;

    mem_copy_engine #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .length   (length),
        .busy     (busy),
        .done     (done),
        .memWrite (memWrite),
        .memRead  (memRead),
        .address  (address),
        .data     (data),
        .out      (out)
`ifdef MEM_COPY_CHECKSUM_EN
        ,
        .checksum (checksum)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural memory: combinational read, write on rising edge.
    assign out = mem[address];
    always @(posedge clk) if (memWrite) mem[address] <= data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Scoreboard monitor: every strobe must match the next expected operation.
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (memRead || memWrite) begin
            check("rw_exclusive", 32'(memRead & memWrite), 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_op", 32'(exp_q.size()), 32'd1);
            end else begin
                op_t e;
                e = exp_q.pop_front();
                check("op", 32'({memWrite, address, (memWrite ? data : 8'h00)}), 32'(e));
            end
        end
    end

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 50);
    endtask

    task automatic do_copy(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l,
                           input int exp_lat, input string tag);
        logic [7:0] snap [256];
        int n;
        for (int i = 0; i < int'(l); i++) begin
            logic [7:0] sa, da;
            sa = s + 8'(i);
            da = d + 8'(i);
            snap[i] = mem[sa];
            exp_q.push_back('{wr: 1'b0, addr: sa, dat: 8'h00});
            exp_q.push_back('{wr: 1'b1, addr: da, dat: mem[sa]});
        end
        @(negedge clk);
        start = 1'b1; src_addr = s; dst_addr = d; length = l;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(n);
        check({tag, "_latency"}, 32'(n), 32'(exp_lat));
        @(negedge clk);
        check({tag, "_done_width"}, 32'(done), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
        check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
        for (int i = 0; i < int'(l); i++) begin
            logic [7:0] da;
            da = d + 8'(i);
            check({tag, "_mem"}, 32'(mem[da]), 32'(snap[i]));
        end
    endtask

    initial begin
        int n;
        int dc;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3);
        rst_n = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; length = '0;
        repeat (3) @(negedge clk);

        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_memread", 32'(memRead), 32'd0);
        check("rst_memwrite", 32'(memWrite), 32'd0);
        check("rst_address", 32'(address), 32'd0);
        check("rst_data", 32'(data), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single byte copy.
        mem[19] = 8'h48;
        do_copy(8'd19, 8'd23, 8'd1, 3, "copy1");
        check("copy1_val", 32'(mem[23]), 32'h48);
`ifdef MEM_COPY_CHECKSUM_EN
        check("copy1_checksum", 32'(checksum), 32'h48);
`endif

        // Three bytes whose sum wraps to zero.
        mem[8'h10] = 8'hAA; mem[8'h11] = 8'h55; mem[8'h12] = 8'h01;
        do_copy(8'h10, 8'h80, 8'd3, 7, "copy3");
`ifdef MEM_COPY_CHECKSUM_EN
        check("copy3_checksum", 32'(checksum), 32'h00);
`endif

        // Source pointer wraps past 0xFF.
        mem[8'hFE] = 8'h11; mem[8'hFF] = 8'h22; mem[8'h00] = 8'h33; mem[8'h01] = 8'h44;
        do_copy(8'hFE, 8'h40, 8'd4, 9, "wrap");

        // Zero length: no strobes, done in the first cycle.
        do_copy(8'h05, 8'h06, 8'd0, 1, "len0");

        // Start held through DONE is accepted again in the following IDLE cycle.
        @(negedge clk);
        start = 1'b1; src_addr = 8'h00; dst_addr = 8'h00; length = 8'd0;
        @(posedge clk);
        wait_done(n);
        check("held_first_done", 32'(n), 32'd1);
        @(negedge clk);
        check("held_idle_gap", 32'(busy), 32'd0);
        @(negedge clk);
        check("held_second_done", 32'(done), 32'd1);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("held_release_idle", 32'(busy | done), 32'd0);

        // Start pulsed while busy is ignored and not queued.
        mem[8'h70] = 8'hC3;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back('{wr: 1'b0, addr: 8'(8'h20 + i), dat: 8'h00});
            exp_q.push_back('{wr: 1'b1, addr: 8'(8'h60 + i), dat: mem[8'h20 + i]});
        end
        #1 dc = done_cnt;
        @(negedge clk);
        start = 1'b1; src_addr = 8'h20; dst_addr = 8'h60; length = 8'd3;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        start = 1'b1; src_addr = 8'h30; dst_addr = 8'h70; length = 8'd1;
        repeat (2) @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        #1;
        check("busy_start_one_done", 32'(done_cnt - dc), 32'd1);
        check("busy_start_sb_empty", 32'(exp_q.size()), 32'd0);
        check("busy_start_no_write", 32'(mem[8'h70]), 32'hC3);
        check("busy_start_mem0", 32'(mem[8'h60]), 32'(mem[8'h20]));

        // Reset after the second write of a five-byte copy.
        for (int i = 0; i < 5; i++) mem[8'hA0 + i] = 8'hEE;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back('{wr: 1'b0, addr: 8'(8'h90 + i), dat: 8'h00});
            exp_q.push_back('{wr: 1'b1, addr: 8'(8'hA0 + i), dat: mem[8'h90 + i]});
        end
        dc = done_cnt;
        @(negedge clk);
        start = 1'b1; src_addr = 8'h90; dst_addr = 8'hA0; length = 8'd5;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_memread", 32'(memRead), 32'd0);
        check("abort_memwrite", 32'(memWrite), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_address", 32'(address), 32'd0);
`ifdef MEM_COPY_CHECKSUM_EN
        check("abort_checksum", 32'(checksum), 32'd0);
`endif
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        check("abort_no_done", 32'(done_cnt - dc), 32'd0);
        check("abort_sb_empty", 32'(exp_q.size()), 32'd0);
        check("abort_mem0", 32'(mem[8'hA0]), 32'(mem[8'h90]));
        check("abort_mem1", 32'(mem[8'hA1]), 32'(mem[8'h91]));
        for (int i = 2; i < 5; i++) check("abort_untouched", 32'(mem[8'hA0 + i]), 32'hEE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_copy_engine.md
MEM_COPY_ENGINE -- requirements
Module: mem_copy_engine

Interface
REQ-001 Parameter ADDR_W, default 8, is the memory address width.
REQ-002 Parameter DATA_W, default 8, is the memory data width.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 Port start, input, 1: copy request, sampled only in IDLE.
REQ-006 Port src_addr, input, ADDR_W: first source address, latched on accepted start.
REQ-007 Port dst_addr, input, ADDR_W: first destination address, latched on accepted start.
REQ-008 Port length, input, ADDR_W: byte count, latched on accepted start; 0 is legal.
REQ-009 Port busy, output, 1: high in every state except IDLE.
REQ-010 Port done, output, 1: one-cycle pulse on completion.
REQ-011 Port memWrite, output, 1: memory write strobe; the memory writes on the rising edge while it is high.
REQ-012 Port memRead, output, 1: memory read strobe.
REQ-013 Port address, output, ADDR_W: memory address.
REQ-014 Port data, output, DATA_W: memory write data.
REQ-015 Port out, input, DATA_W: memory read data, valid in the same cycle memRead is high.

Function
REQ-016 The FSM SHALL have states IDLE, READ, WRITE, DONE.
REQ-017 IDLE with start=1 at an edge: latch src, dst and length; go to READ if length!=0, otherwise go to DONE.
REQ-018 READ: memRead=1, address=src pointer; at the edge, capture out into the byte buffer and go to WRITE.
REQ-019 WRITE: memWrite=1, address=dst pointer, data=buffer.
REQ-019a At the WRITE edge: increment both pointers and decrement the count; go to DONE if the count reaches 0, else go to READ.
REQ-020 DONE: done=1 for exactly one cycle, then go to IDLE.
REQ-021 Each byte costs exactly 2 cycles; the start edge to the done cycle takes 2*length+1 cycles, or 1 cycle for length 0.
REQ-022 Pointer increments SHALL wrap modulo 2^ADDR_W (0xFF+1 -> 0x00).
REQ-023 The copy SHALL be strictly ascending; overlapping regions are not corrected.
REQ-024 memRead and memWrite SHALL never be high in the same cycle.
REQ-025 In IDLE and DONE, memRead=0, memWrite=0, address=0 and data=0.
REQ-026 A start asserted while busy=1 SHALL be ignored and SHALL not be queued.
REQ-027 A start held high through DONE SHALL be accepted in the following IDLE cycle.

Reset
REQ-028 rst_n=0 SHALL immediately force state IDLE and drive busy, done, memRead, memWrite, address and data to 0, without waiting for a clock edge.
REQ-029 A reset mid-copy SHALL abort the copy with no done pulse.
REQ-030 Bytes already written before the reset remain in memory; no further writes occur after the reset.
REQ-031 Every internal register (pointers, count, buffer, checksum) SHALL reset to 0.

Configuration
REQ-032 Macro MEM_COPY_CHECKSUM_EN, when defined, SHALL add output checksum (DATA_W).
REQ-033 checksum is the modulo-2^DATA_W sum of all bytes copied by the current copy.
REQ-034 checksum clears on accepted start, accumulates each captured byte, and is stable from DONE until the next accepted start.
REQ-035 Without MEM_COPY_CHECKSUM_EN, the checksum port and its logic SHALL be absent and all other behaviour is identical.

Verification
REQ-036 Copy one byte: preload mem[19]=0x48; start with src=19, dst=23, length=1 -> READ@19, WRITE@23 with data 0x48, done 3 cycles after the start edge, mem[23]=0x48.
REQ-037 Copy three bytes: mem[0x10..0x12]=0xAA,0x55,0x01; src=0x10, dst=0x80, length=3 -> mem[0x80..0x82] match, done after 7 cycles, checksum=0x00 (with macro).
REQ-038 Wrap: src=0xFE, dst=0x40, length=4 -> reads at 0xFE,0xFF,0x00,0x01 in order.
REQ-039 length=0 -> no memRead or memWrite; done pulses in the cycle after the start edge.
REQ-040 start pulsed again while busy -> ignored; exactly one done pulse; memory matches a single copy.
REQ-041 rst_n low after the second WRITE of a length-5 copy -> strobes drop without a clock edge; no done pulse; only 2 destination bytes changed.
